simple_sync_fifo: RTL and testbench

//  Single-clock synchronous FIFO with an scfifo-style interface (normal, non-show-ahead read).

---
 rtl/simple_sync_fifo.sv | 77 +++++++
 tb/tb_simple_sync_fifo.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/simple_sync_fifo.sv
// Single-clock synchronous FIFO with an scfifo-style, non-show-ahead read port.
// Depth is 2**widthu words. All flags derive from a registered fill count.
module simple_sync_fifo #(
  parameter int width  = 8,
  parameter int widthu = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclr,
  input  logic              rdreq,
  input  logic              wrreq,
  input  logic [width-1:0]  data,
  output logic              empty,
  output logic              full,
  output logic [width-1:0]  q,
  output logic [widthu-1:0] usedw
);

  localparam int DEPTH = 1 << widthu;
  localparam logic [widthu:0] COUNT_FULL = (widthu+1)'(DEPTH);

  logic [width-1:0]  mem [DEPTH];
  logic [widthu-1:0] wptr;
  logic [widthu-1:0] rptr;
  logic [widthu:0]   count;
  logic              clr;
  logic              wr_en;
  logic              rd_en;

  // Fill count moves by one on a lone write or lone read; a paired access nets to zero.
  function automatic logic [widthu:0] next_count(input logic [widthu:0] c,
                                                 input logic w,
                                                 input logic r);
    logic [widthu:0] n;
    n = c;
    case ({w, r})
      2'b10:   n = c + 1'b1;
      2'b01:   n = c - 1'b1;
      default: n = c;
    endcase
    return n;
  endfunction

  assign clr   = rst | sclr;
  assign wr_en = wrreq & ~full & ~clr;
  assign rd_en = rdreq & ~empty & ~clr;

  assign empty = (count == '0);
  assign full  = (count == COUNT_FULL);
  assign usedw = count[widthu-1:0];

  // Storage needs no clearing; stale words are unreachable once the pointers reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr] <= data;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      q     <= '0;
    end else begin
      if (wr_en) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_en) begin
        rptr <= rptr + 1'b1;
        q    <= mem[rptr];
      end
      count <= next_count(count, wr_en, rd_en);
    end
  end

endmodule

// File: tb/tb_simple_sync_fifo.sv
// Directed bench for simple_sync_fifo (width=8, widthu=3) with hand-computed expectations.
module tb_simple_sync_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sclr = 1'b0;
  logic       rdreq = 1'b0;
  logic       wrreq = 1'b0;
  logic [7:0] data = 8'h00;
  logic       empty;
  logic       full;
  logic [7:0] q;
  logic [2:0] usedw;

  int vectors = 0;
  int miscompares = 0;

  simple_sync_fifo #(.width(8), .widthu(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .sclr  (sclr),
    .rdreq (rdreq),
    .wrreq (wrreq),
    .data  (data),
    .empty (empty),
    .full  (full),
    .q     (q),
    .usedw (usedw)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_empty"}, empty, 1'b1);
    chk({tag, "_full"},  full,  1'b0);
    chk({tag, "_usedw"}, usedw, 3'd0);
    chk({tag, "_q"},     q,     8'h00);
  endtask

  initial begin
    #1;
    // 1: reset
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_cleared("s1");

    // 2: single word, then over-reads
    wrreq = 1'b1; data = 8'hAA;
    tick();
    wrreq = 1'b0;
    chk("s2_usedw", usedw, 3'd1);
    chk("s2_empty", empty, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    rdreq = 1'b1;
    tick();
    chk("s2_q", q, 8'hAA);
    chk("s2_empty_after", empty, 1'b1);
    chk("s2_usedw_after", usedw, 3'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s2_q_hold", q, 8'hAA);
      chk("s2_empty_hold", empty, 1'b1);
    end
    rdreq = 1'b0;

    // 3: fill to full, overflow, write-while-full with read
    for (int i = 0; i < 8; i++) begin
      wrreq = 1'b1; data = 8'(i);
      tick();
    end
    chk("s3_full", full, 1'b1);
    chk("s3_usedw", usedw, 3'd0);
    chk("s3_empty", empty, 1'b0);
    data = 8'hFF;
    tick();
    chk("s3_full_ovf", full, 1'b1);
    rdreq = 1'b1; wrreq = 1'b1; data = 8'hEE;
    tick();
    wrreq = 1'b0;
    chk("s3_q0", q, 8'h00);
    chk("s3_usedw7", usedw, 3'd7);
    chk("s3_full_drop", full, 1'b0);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("s3_q", q, 32'(i));
    end
    rdreq = 1'b0;
    chk("s3_empty_end", empty, 1'b1);

    // 4: steady state at 5 words through pointer wrap
    for (int i = 0; i < 5; i++) begin
      wrreq = 1'b1; data = 8'h10 + 8'(i);
      tick();
    end
    chk("s4_usedw_fill", usedw, 3'd5);
    rdreq = 1'b1;
    for (int i = 0; i < 20; i++) begin
      data = 8'h15 + 8'(i);
      tick();
      chk("s4_q", q, 32'h10 + 32'(i));
      chk("s4_usedw", usedw, 3'd5);
    end
    wrreq = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s4_drain_q", q, 32'h24 + 32'(i));
    end
    rdreq = 1'b0;
    chk("s4_empty", empty, 1'b1);

    // 5: sclr with a concurrent write
    for (int i = 0; i < 6; i++) begin
      wrreq = 1'b1; data = 8'h40 + 8'(i);
      tick();
    end
    chk("s5_usedw_fill", usedw, 3'd6);
    sclr = 1'b1; data = 8'h99;
    tick();
    sclr = 1'b0; wrreq = 1'b0;
    check_cleared("s5");
    wrreq = 1'b1; data = 8'h5A;
    tick();
    wrreq = 1'b0;
    chk("s5_usedw_new", usedw, 3'd1);
    rdreq = 1'b1;
    tick();
    rdreq = 1'b0;
    chk("s5_q_new", q, 8'h5A);
    chk("s5_empty_new", empty, 1'b1);

    // 6: rst with words stored and a pending read
    for (int i = 0; i < 3; i++) begin
      wrreq = 1'b1; data = 8'h70 + 8'(i);
      tick();
    end
    wrreq = 1'b0;
    chk("s6_usedw_fill", usedw, 3'd3);
    rdreq = 1'b1; rst = 1'b1;
    tick();
    rdreq = 1'b0; rst = 1'b0;
    check_cleared("s6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
